// File: rtl/fetch_stage_q.sv
// Queued fetch stage: FQ_DEPTH-entry fetch queue between a pipelined valid/ready imem and decode.
// Redirects (trap > mret > pc_src) flush the queue and drop in-flight responses.
// Optional: define FETCH_PERF_CNT_EN to add saturating perf_fetched / perf_flushed counters.
module fetch_stage_q #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(19)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            pc_src,
    input  logic [XLEN-1:0] jump_address,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_misaligned
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic            mis;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t          q_mem   [FQ_DEPTH];
    logic [XLEN-1:0] tag_mem [FQ_DEPTH];
    logic [PW-1:0]   q_rd, q_wr, t_rd, t_wr;
    logic [CW-1:0]   occ, outstanding, drop;
    logic [XLEN-1:0] pc;
    logic            running;
    logic            mis_done;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            req_hs;
    logic            rsp_take;
    logic            rsp_drop;
    logic            mis_push;
    logic            push;
    logic            pop;
    entry_t          push_entry;

    // Issue credit, response routing, push/pop and head presentation
    always_comb begin
        redirect       = trap | mret | pc_src;
        target         = trap ? trap_vec : (mret ? mepc : jump_address);
        imem_req_addr  = pc;
        imem_req_valid = running && (pc[1:0] == 2'b00)
                         && ((SW'(occ) + SW'(outstanding)) < SW'(FQ_DEPTH))
                         && ((SW'(outstanding) + SW'(drop)) < SW'(FQ_DEPTH));
        req_hs         = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop != '0);
        rsp_take       = imem_rsp_valid && (drop == '0) && (outstanding != '0);
        mis_push       = running && (pc[1:0] != 2'b00) && !mis_done
                         && (outstanding == '0) && (occ != CW'(FQ_DEPTH));
        push           = !redirect && (rsp_take || mis_push);
        push_entry     = '{mis: 1'b1, pc: pc, inst: NOP_INST};
        if (rsp_take) begin
            push_entry = '{mis: 1'b0, pc: tag_mem[t_rd], inst: imem_rsp_data};
        end
        id_valid       = (occ != '0);
        pop            = id_valid && id_ready && !redirect;
        id_pc          = '0;
        id_inst        = NOP_INST;
        id_misaligned  = 1'b0;
        if (id_valid) begin
            id_pc         = q_mem[q_rd].pc;
            id_inst       = q_mem[q_rd].inst;
            id_misaligned = q_mem[q_rd].mis;
        end
    end

    // Control state: PC, queue/tag pointers, credit counters, misaligned stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
            occ         <= '0;
            outstanding <= '0;
            drop        <= '0;
            running     <= 1'b0;
            mis_done    <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redirect) begin
                pc          <= target;
                q_rd        <= '0;
                q_wr        <= '0;
                t_rd        <= '0;
                t_wr        <= '0;
                occ         <= '0;
                outstanding <= '0;
                drop        <= CW'(SW'(drop) + SW'(outstanding) + SW'(req_hs)
                                  - SW'(rsp_take) - SW'(rsp_drop));
                mis_done    <= 1'b0;
            end else begin
                if (req_hs) begin
                    pc   <= pc + XLEN'(4);
                    t_wr <= t_wr + PW'(1);
                end
                if (rsp_take) begin
                    t_rd <= t_rd + PW'(1);
                end
                if (rsp_drop) begin
                    drop <= drop - CW'(1);
                end
                outstanding <= CW'(SW'(outstanding) + SW'(req_hs) - SW'(rsp_take));
                if (push) begin
                    q_wr <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
                occ <= CW'(SW'(occ) + SW'(push) - SW'(pop));
                if (mis_push) begin
                    mis_done <= 1'b1;
                end
            end
        end
    end

    // Storage for the request-PC tags and the queue payloads (no reset needed)
    always_ff @(posedge clk) begin
        if (rst && !redirect && req_hs) begin
            tag_mem[t_wr] <= pc;
        end
        if (rst && push) begin
            q_mem[q_wr] <= push_entry;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] flushed_sum;

    // Saturating sum of discarded responses and queue entries flushed by a redirect
    always_comb begin
        flushed_sum = 33'(perf_flushed) + 33'(rsp_drop || (redirect && rsp_take));
        if (redirect) begin
            flushed_sum = flushed_sum + 33'(occ);
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule
